// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: NUM_REGS-NUM_RO read/write control registers
// followed by NUM_RO hardware-fed status registers, with per-register write pulses.
module axi_lite_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS           = 8,
  parameter int NUM_RO             = 2
) (
  input  logic                                           ACLK,
  input  logic                                           ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                  S_AXI_AWADDR,
  input  logic [2:0]                                     S_AXI_AWPROT,
  input  logic                                           S_AXI_AWVALID,
  output logic                                           S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                  S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]                S_AXI_WSTRB,
  input  logic                                           S_AXI_WVALID,
  output logic                                           S_AXI_WREADY,
  output logic [1:0]                                     S_AXI_BRESP,
  output logic                                           S_AXI_BVALID,
  input  logic                                           S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                  S_AXI_ARADDR,
  input  logic [2:0]                                     S_AXI_ARPROT,
  input  logic                                           S_AXI_ARVALID,
  output logic                                           S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]                  S_AXI_RDATA,
  output logic [1:0]                                     S_AXI_RRESP,
  output logic                                           S_AXI_RVALID,
  input  logic                                           S_AXI_RREADY,
  output logic [(NUM_REGS-NUM_RO)*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_RO*C_S_AXI_DATA_WIDTH-1:0]           reg_in,
  output logic [NUM_REGS-NUM_RO-1:0]                     wr_pulse
);

  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int AW  = C_S_AXI_ADDR_WIDTH;
  localparam int SW  = DW / 8;
  localparam int LSB = $clog2(SW);
  localparam int IW  = AW - LSB;
  localparam int NRW = NUM_REGS - NUM_RO;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  logic              rdy_en_q;
  wstate_e           wstate_q, wstate_d;
  logic [IW-1:0]     widx_q, widx_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [SW-1:0]     wstrb_q, wstrb_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [NRW-1:0]    wr_pulse_q, wr_pulse_d;
  logic [DW-1:0]     regs_q [NRW];
  logic [DW-1:0]     regs_d [NRW];
  rstate_e           rstate_q, rstate_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic              awready, wready, arready;
  logic              aw_hs, w_hs, ar_hs;
  logic [IW-1:0]     aw_idx, ar_idx;
  logic              commit;
  logic [IW-1:0]     c_idx;
  logic [DW-1:0]     c_data;
  logic [SW-1:0]     c_strb;
  logic              unused_bits;

  function automatic logic is_rw(input logic [IW-1:0] idx);
    return int'(idx) < NRW;
  endfunction

  assign aw_idx  = S_AXI_AWADDR[AW-1:LSB];
  assign ar_idx  = S_AXI_ARADDR[AW-1:LSB];
  assign awready = rdy_en_q && (wstate_q == W_IDLE || wstate_q == W_HAVE_D);
  assign wready  = rdy_en_q && (wstate_q == W_IDLE || wstate_q == W_HAVE_A);
  assign arready = rdy_en_q && (rstate_q == R_IDLE);
  assign aw_hs   = S_AXI_AWVALID && awready;
  assign w_hs    = S_AXI_WVALID && wready;
  assign ar_hs   = S_AXI_ARVALID && arready;

  // Write channel: address and data may arrive in either order; commit once both are held.
  always_comb begin
    wstate_d   = wstate_q;
    widx_d     = widx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;
    commit     = 1'b0;
    c_idx      = widx_q;
    c_data     = wdata_q;
    c_strb     = wstrb_q;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
          c_idx  = aw_idx;
          c_data = S_AXI_WDATA;
          c_strb = S_AXI_WSTRB;
        end else if (aw_hs) begin
          widx_d   = aw_idx;
          wstate_d = W_HAVE_A;
        end else if (w_hs) begin
          wdata_d  = S_AXI_WDATA;
          wstrb_d  = S_AXI_WSTRB;
          wstate_d = W_HAVE_D;
        end
      end
      W_HAVE_A: begin
        if (w_hs) begin
          commit = 1'b1;
          c_data = S_AXI_WDATA;
          c_strb = S_AXI_WSTRB;
        end
      end
      W_HAVE_D: begin
        if (aw_hs) begin
          commit = 1'b1;
          c_idx  = aw_idx;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) wstate_d = W_IDLE;
      end
    endcase

    if (commit) begin
      wstate_d = W_RESP;
      bresp_d  = is_rw(c_idx) ? RESP_OKAY : RESP_SLVERR;
      for (int i = 0; i < NRW; i++) begin
        if (int'(c_idx) == i) begin
          wr_pulse_d[i] = 1'b1;
          for (int b = 0; b < SW; b++) begin
            if (c_strb[b]) regs_d[i][b*8 +: 8] = c_data[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read channel: data is captured on the AR handshake, so RW reads see the pre-commit value.
  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs) begin
          rstate_d = R_DATA;
          rdata_d  = '0;
          rresp_d  = RESP_SLVERR;
          for (int i = 0; i < NRW; i++) begin
            if (int'(ar_idx) == i) begin
              rdata_d = regs_q[i];
              rresp_d = RESP_OKAY;
            end
          end
          for (int j = 0; j < NUM_RO; j++) begin
            if (int'(ar_idx) == NRW + j) begin
              rdata_d = reg_in[j*DW +: DW];
              rresp_d = RESP_OKAY;
            end
          end
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) rstate_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdy_en_q   <= 1'b0;
      wstate_q   <= W_IDLE;
      widx_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= '0;
      wr_pulse_q <= '0;
      rstate_q   <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= '0;
      for (int i = 0; i < NRW; i++) regs_q[i] <= '0;
    end else begin
      rdy_en_q   <= 1'b1;
      wstate_q   <= wstate_d;
      widx_q     <= widx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      rstate_q   <= rstate_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      for (int i = 0; i < NRW; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_BVALID  = (wstate_q == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = (rstate_q == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign wr_pulse      = wr_pulse_q;

  for (genvar g = 0; g < NRW; g++) begin : g_reg_out
    assign reg_out[g*DW +: DW] = regs_q[g];
  end

  // Protection bits and sub-word address bits carry no meaning for this bank.
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed and randomized bench for axi_lite_regbank against an array-based
// register model (default parameters: 32-bit data, 6 RW + 2 RO registers).
module tb_axi_lite_regbank;

  localparam int NRW = 6;
  localparam int NR  = 8;

  logic         ACLK = 1'b0;
  logic         ARESETN;
  logic [5:0]   S_AXI_AWADDR;
  logic [2:0]   S_AXI_AWPROT;
  logic         S_AXI_AWVALID;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic         S_AXI_WVALID;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY;
  logic [5:0]   S_AXI_ARADDR;
  logic [2:0]   S_AXI_ARPROT;
  logic         S_AXI_ARVALID;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY;
  logic [191:0] reg_out;
  logic [63:0]  reg_in;
  logic [5:0]   wr_pulse;

  int total = 0;
  int bad   = 0;
  logic [31:0] model [NRW];

  axi_lite_regbank dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < NRW; i++) chk(tag, reg_out[i*32 +: 32], model[i]);
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_dly);
    int c;
    int idx;
    bit aw_done, w_done, aw_hs, w_hs;
    logic [1:0]  eresp;
    logic [5:0]  epulse;
    logic [31:0] mask;
    idx     = int'(addr) / 4;
    eresp   = (idx < NRW) ? 2'b00 : 2'b10;
    epulse  = (idx < NRW) ? (6'b1 << idx) : 6'b0;
    c       = 0;
    aw_done = 0;
    w_done  = 0;
    while (!(aw_done && w_done) && c < 50) begin
      if (!aw_done && c >= aw_dly) begin S_AXI_AWVALID = 1'b1; S_AXI_AWADDR = addr; end
      if (!w_done && c >= w_dly) begin
        S_AXI_WVALID = 1'b1; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
      end
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      if (aw_hs) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
      if (w_hs) begin w_done = 1; S_AXI_WVALID = 1'b0; end
      if (aw_done != w_done) begin
        chk("bvalid_early", S_AXI_BVALID, 1'b0);
        chk("awready_half", S_AXI_AWREADY, !aw_done);
        chk("wready_half", S_AXI_WREADY, !w_done);
      end
      c++;
    end
    chk("wr_hs_done", {aw_done, w_done}, 2'b11);
    if (idx < NRW) begin
      mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      model[idx] = (model[idx] & ~mask) | (data & mask);
    end
    chk("bvalid_rise", S_AXI_BVALID, 1'b1);
    chk("bresp", S_AXI_BRESP, eresp);
    chk("wr_pulse_rise", wr_pulse, epulse);
    chk_regs("reg_out_after_wr");
    S_AXI_BREADY = (b_dly == 0);
    for (int k = 0; k < b_dly; k++) begin
      tick();
      chk("bvalid_hold", S_AXI_BVALID, 1'b1);
      chk("bresp_hold", S_AXI_BRESP, eresp);
      chk("ready_in_resp", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
      chk("wr_pulse_one_cycle", wr_pulse, 6'b0);
      if (k == b_dly - 1) S_AXI_BREADY = 1'b1;
    end
    tick();
    S_AXI_BREADY = 1'b0;
    chk("bvalid_drop", S_AXI_BVALID, 1'b0);
    chk("wr_pulse_after", wr_pulse, 6'b0);
  endtask

  task automatic axi_read(input logic [5:0] addr, input int r_dly);
    int c;
    int idx;
    bit hs;
    logic [31:0] edata;
    logic [1:0]  eresp;
    idx = int'(addr) / 4;
    if (idx < NRW) begin
      edata = model[idx]; eresp = 2'b00;
    end else if (idx < NR) begin
      edata = reg_in[(idx - NRW)*32 +: 32]; eresp = 2'b00;
    end else begin
      edata = 32'h0; eresp = 2'b10;
    end
    S_AXI_ARVALID = 1'b1;
    S_AXI_ARADDR  = addr;
    c  = 0;
    hs = 0;
    while (!hs && c < 50) begin
      hs = S_AXI_ARREADY;
      tick();
      c++;
    end
    S_AXI_ARVALID = 1'b0;
    chk("ar_hs_done", hs, 1'b1);
    chk("rvalid_rise", S_AXI_RVALID, 1'b1);
    chk("rdata", S_AXI_RDATA, edata);
    chk("rresp", S_AXI_RRESP, eresp);
    chk("arready_busy", S_AXI_ARREADY, 1'b0);
    for (int k = 0; k < r_dly; k++) begin
      tick();
      chk("rvalid_hold", S_AXI_RVALID, 1'b1);
      chk("rdata_hold", S_AXI_RDATA, edata);
      chk("rresp_hold", S_AXI_RRESP, eresp);
    end
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
    chk("rvalid_drop", S_AXI_RVALID, 1'b0);
  endtask

  initial begin
    ARESETN       = 1'b0;
    S_AXI_AWADDR  = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA   = '0; S_AXI_WSTRB  = '0; S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY  = 1'b0;
    S_AXI_ARADDR  = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY  = 1'b0;
    reg_in        = {32'hCAFE0001, 32'hBEEF0002};
    for (int i = 0; i < NRW; i++) model[i] = 32'h0;

    #1;
    chk("rst_readys", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    chk("rst_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
    chk("rst_wr_pulse", wr_pulse, 6'b0);
    chk("rst_rdata", S_AXI_RDATA, 32'h0);
    chk_regs("rst_reg_out");
    repeat (3) tick();
    ARESETN = 1'b1;
    chk("first_cycle_readys", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    tick();
    chk("readys_enabled", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

    for (int i = 0; i < 6; i++) axi_read(6'(i * 4), 0);

    for (int i = 0; i < 4; i++) axi_write(6'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(6'(i * 4), 0);

    axi_write(6'h10, 32'h11223344, 4'hF, 0, 0, 0);
    axi_write(6'h10, 32'hAABBCCDD, 4'h5, 0, 0, 0);
    axi_read(6'h10, 0);
    chk("strobe_merge", S_AXI_RDATA, 32'h11BB33DD);

    axi_write(6'h14, 32'h5A5A0001, 4'hF, 1, 0, 0);
    axi_read(6'h14, 1);
    axi_write(6'h14, 32'h0000A5A5, 4'h3, 0, 3, 4);
    axi_read(6'h14, 2);
    axi_write(6'h04, 32'hFFFFFFFF, 4'h0, 0, 0, 1);

    axi_read(6'h18, 0);
    axi_read(6'h1C, 0);
    axi_write(6'h18, 32'h12345678, 4'hF, 0, 0, 0);
    axi_read(6'h18, 0);
    axi_read(6'h20, 0);
    axi_write(6'h2C, 32'h87654321, 4'hF, 2, 0, 0);

    fork
      axi_write(6'h08, 32'h9, 4'hF, 0, 0, 0);
      axi_read(6'h08, 0);
    join
    axi_read(6'h08, 0);

    S_AXI_AWVALID = 1'b1;
    S_AXI_AWADDR  = 6'h04;
    tick();
    S_AXI_AWVALID = 1'b0;
    chk("have_a_readys", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b01);
    ARESETN = 1'b0;
    for (int i = 0; i < NRW; i++) model[i] = 32'h0;
    S_AXI_WVALID = 1'b1; S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF;
    #1;
    chk("midrst_bvalid", S_AXI_BVALID, 1'b0);
    chk("midrst_readys", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    chk_regs("midrst_cleared");
    repeat (2) tick();
    S_AXI_WVALID = 1'b0;
    ARESETN = 1'b1;
    chk("rerel_readys", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rerel_no_bvalid", S_AXI_BVALID, 1'b0);
    end
    axi_read(6'h04, 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        axi_write(6'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        if ($urandom_range(0, 3) == 0) reg_in = {$urandom, $urandom};
        axi_read(6'($urandom_range(0, 63)), $urandom_range(0, 3));
      end
    end
    chk_regs("final_reg_out");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
